reg_status_table: RTL and testbench

//  Per-register rename/scoreboard controller that sits in front of RegisterFile in the OoO core.
//  - Records which ROB entry (tag) will produce each architectural register.
//  - Sequences commit writes into RegisterFile.
//  - Answers issue-stage operand queries with either a value or a pending ROB tag.
//  - Bypasses the value being committed in the same cycle.

---
 rtl/reg_status_table.sv | 97 +++++++++
 tb/tb_reg_status_table.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/reg_status_table.sv
// ============================================================================
// reg_status_table : rename/scoreboard front-end for RegisterFile (busy, tag, bypass)
// Revision: 1.0
// ============================================================================
`default_nettype none

module reg_status_table #(
    parameter int ROB_WIDTH = 3
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 flush_in,
    input  logic                 issue_valid,
    input  logic [4:0]           issue_rd,
    input  logic [ROB_WIDTH-1:0] issue_tag,
    input  logic                 commit_valid,
    input  logic [4:0]           commit_rd,
    input  logic [ROB_WIDTH-1:0] commit_tag,
    input  logic [31:0]          commit_val,
    input  logic [4:0]           rs1_id,
    input  logic [4:0]           rs2_id,
    output logic                 rs1_busy,
    output logic [ROB_WIDTH-1:0] rs1_tag,
    output logic [31:0]          rs1_val,
    output logic                 rs2_busy,
    output logic [ROB_WIDTH-1:0] rs2_tag,
    output logic [31:0]          rs2_val,
    output logic [4:0]           rf_set_id,
    output logic [31:0]          rf_set_val,
    output logic [4:0]           rf_get_id1,
    output logic [4:0]           rf_get_id2,
    input  logic [31:0]          rf_get_val1,
    input  logic [31:0]          rf_get_val2
);

    logic                 r_busy [32];
    logic [ROB_WIDTH-1:0] r_tag  [32];
    logic                 w_commit_fire;
    logic                 w_rs1_hit;
    logic                 w_rs2_hit;

    assign w_commit_fire = commit_valid && rdy_in;

    // x0 is hardwired idle so every lookup can index the arrays uniformly.
    assign r_busy[0] = 1'b0;
    assign r_tag[0]  = '0;

    generate
        for (genvar i = 1; i < 32; i++) begin : g_reg
            logic w_issue_hit;
            logic w_commit_hit;

            assign w_issue_hit  = issue_valid && (issue_rd == 5'(i));
            assign w_commit_hit = commit_valid && (commit_rd == 5'(i))
                                  && r_busy[i] && (r_tag[i] == commit_tag);

            always_ff @(posedge clk_in) begin
                if (!rst_in) begin
                    r_busy[i] <= 1'b0;
                    r_tag[i]  <= '0;
                end else if (rdy_in) begin
                    if (flush_in) begin
                        r_busy[i] <= 1'b0;
                    end else if (w_issue_hit) begin
                        // A rename in the same cycle supersedes the retiring producer.
                        r_busy[i] <= 1'b1;
                        r_tag[i]  <= issue_tag;
                    end else if (w_commit_hit) begin
                        r_busy[i] <= 1'b0;
                    end
                end
            end
        end
    endgenerate

    assign w_rs1_hit = w_commit_fire && (commit_rd == rs1_id)
                       && r_busy[rs1_id] && (r_tag[rs1_id] == commit_tag);
    assign w_rs2_hit = w_commit_fire && (commit_rd == rs2_id)
                       && r_busy[rs2_id] && (r_tag[rs2_id] == commit_tag);

    assign rs1_busy = r_busy[rs1_id] && !w_rs1_hit;
    assign rs1_tag  = r_tag[rs1_id];
    assign rs1_val  = (rs1_id == 5'd0) ? 32'd0 : (w_rs1_hit ? commit_val : rf_get_val1);

    assign rs2_busy = r_busy[rs2_id] && !w_rs2_hit;
    assign rs2_tag  = r_tag[rs2_id];
    assign rs2_val  = (rs2_id == 5'd0) ? 32'd0 : (w_rs2_hit ? commit_val : rf_get_val2);

    assign rf_set_id  = w_commit_fire ? commit_rd : 5'd0;
    assign rf_set_val = commit_val;
    assign rf_get_id1 = rs1_id;
    assign rf_get_id2 = rs2_id;

endmodule

`default_nettype wire

// File: tb/tb_reg_status_table.sv
// ============================================================================
// tb_reg_status_table : directed self-checking bench for reg_status_table
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_reg_status_table;

    localparam int ROB_WIDTH = 3;

    logic                 clk_in = 1'b0;
    logic                 rst_in;
    logic                 rdy_in;
    logic                 flush_in;
    logic                 issue_valid;
    logic [4:0]           issue_rd;
    logic [ROB_WIDTH-1:0] issue_tag;
    logic                 commit_valid;
    logic [4:0]           commit_rd;
    logic [ROB_WIDTH-1:0] commit_tag;
    logic [31:0]          commit_val;
    logic [4:0]           rs1_id;
    logic [4:0]           rs2_id;
    logic                 rs1_busy;
    logic [ROB_WIDTH-1:0] rs1_tag;
    logic [31:0]          rs1_val;
    logic                 rs2_busy;
    logic [ROB_WIDTH-1:0] rs2_tag;
    logic [31:0]          rs2_val;
    logic [4:0]           rf_set_id;
    logic [31:0]          rf_set_val;
    logic [4:0]           rf_get_id1;
    logic [4:0]           rf_get_id2;
    logic [31:0]          rf_get_val1;
    logic [31:0]          rf_get_val2;

    int n_total  = 0;
    int n_passed = 0;

    always #5 clk_in = ~clk_in;

    // Register file stand-in: value is a recognisable function of the queried id.
    assign rf_get_val1 = 32'hA000_0000 | {27'd0, rs1_id};
    assign rf_get_val2 = 32'hB000_0000 | {27'd0, rs2_id};

    reg_status_table #(.ROB_WIDTH(ROB_WIDTH)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .flush_in     (flush_in),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .issue_tag    (issue_tag),
        .commit_valid (commit_valid),
        .commit_rd    (commit_rd),
        .commit_tag   (commit_tag),
        .commit_val   (commit_val),
        .rs1_id       (rs1_id),
        .rs2_id       (rs2_id),
        .rs1_busy     (rs1_busy),
        .rs1_tag      (rs1_tag),
        .rs1_val      (rs1_val),
        .rs2_busy     (rs2_busy),
        .rs2_tag      (rs2_tag),
        .rs2_val      (rs2_val),
        .rf_set_id    (rf_set_id),
        .rf_set_val   (rf_set_val),
        .rf_get_id1   (rf_get_id1),
        .rf_get_id2   (rf_get_id2),
        .rf_get_val1  (rf_get_val1),
        .rf_get_val2  (rf_get_val2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_passed++;
        else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    // Advance past the next rising edge; inputs are then changed mid-cycle.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0;
        issue_valid = 1'b0; issue_rd = '0; issue_tag = '0;
        commit_valid = 1'b0; commit_rd = '0; commit_tag = '0; commit_val = '0;
        rs1_id = '0; rs2_id = '0;
        tick(); tick();
        rst_in = 1'b1;

        // Reset state
        rs1_id = 5'd5; rs2_id = 5'd0; settle();
        chk("rst_rs1_busy", 32'(rs1_busy), 32'd0);
        chk("rst_rs1_val",  rs1_val, 32'hA000_0005);
        chk("rst_rs2_x0_val", rs2_val, 32'd0);
        chk("rst_rf_set_id", 32'(rf_set_id), 32'd0);

        // Issue and bypass on commit
        issue_valid = 1'b1; issue_rd = 5'd3; issue_tag = 3'd2; rs1_id = 5'd3; settle();
        chk("issue_own_operand_busy", 32'(rs1_busy), 32'd0);
        tick();
        issue_valid = 1'b0; settle();
        chk("x3_busy", 32'(rs1_busy), 32'd1);
        chk("x3_tag",  32'(rs1_tag), 32'd2);
        commit_valid = 1'b1; commit_rd = 5'd3; commit_tag = 3'd2; commit_val = 32'h0000_DEAD; settle();
        chk("bypass_busy", 32'(rs1_busy), 32'd0);
        chk("bypass_val",  rs1_val, 32'h0000_DEAD);
        chk("commit_rf_set_id", 32'(rf_set_id), 32'd3);
        chk("commit_rf_set_val", rf_set_val, 32'h0000_DEAD);
        tick();
        commit_valid = 1'b0; settle();
        chk("x3_cleared_busy", 32'(rs1_busy), 32'd0);
        chk("x3_cleared_val",  rs1_val, 32'hA000_0003);

        // Stale commit after rename
        issue_valid = 1'b1; issue_rd = 5'd4; issue_tag = 3'd1; tick();
        issue_tag = 3'd5; tick();
        issue_valid = 1'b0;
        commit_valid = 1'b1; commit_rd = 5'd4; commit_tag = 3'd1; commit_val = 32'h1234; rs2_id = 5'd4; settle();
        chk("stale_rf_set_id", 32'(rf_set_id), 32'd4);
        chk("stale_no_bypass_busy", 32'(rs2_busy), 32'd1);
        chk("stale_no_bypass_tag", 32'(rs2_tag), 32'd5);
        tick();
        commit_valid = 1'b0; settle();
        chk("stale_x4_busy", 32'(rs2_busy), 32'd1);
        chk("stale_x4_tag",  32'(rs2_tag), 32'd5);

        // Same-cycle commit and re-issue to x6
        issue_valid = 1'b1; issue_rd = 5'd6; issue_tag = 3'd2; tick();
        issue_tag = 3'd7;
        commit_valid = 1'b1; commit_rd = 5'd6; commit_tag = 3'd2; commit_val = 32'h6666; rs1_id = 5'd6; settle();
        chk("x6_bypass_val", rs1_val, 32'h6666);
        chk("x6_bypass_busy", 32'(rs1_busy), 32'd0);
        tick();
        issue_valid = 1'b0; commit_valid = 1'b0; settle();
        chk("x6_issue_wins_busy", 32'(rs1_busy), 32'd1);
        chk("x6_issue_wins_tag",  32'(rs1_tag), 32'd7);

        // Flush clears everything and drops the concurrent issue
        issue_valid = 1'b1;
        issue_rd = 5'd1; issue_tag = 3'd1; tick();
        issue_rd = 5'd2; issue_tag = 3'd2; tick();
        issue_rd = 5'd3; issue_tag = 3'd3; tick();
        rs1_id = 5'd1; rs2_id = 5'd2; settle();
        chk("preflush_x1_busy", 32'(rs1_busy), 32'd1);
        chk("preflush_x2_tag", 32'(rs2_tag), 32'd2);
        flush_in = 1'b1; issue_rd = 5'd9; issue_tag = 3'd4; tick();
        flush_in = 1'b0; issue_valid = 1'b0; settle();
        chk("flush_x1_busy", 32'(rs1_busy), 32'd0);
        chk("flush_x2_busy", 32'(rs2_busy), 32'd0);
        rs1_id = 5'd3; rs2_id = 5'd9; settle();
        chk("flush_x3_busy", 32'(rs1_busy), 32'd0);
        chk("flush_x9_busy", 32'(rs2_busy), 32'd0);
        rs1_id = 5'd4; rs2_id = 5'd6; settle();
        chk("flush_x4_busy", 32'(rs1_busy), 32'd0);
        chk("flush_x6_busy", 32'(rs2_busy), 32'd0);

        // x0 never busy
        issue_valid = 1'b1; issue_rd = 5'd0; issue_tag = 3'd6; tick();
        issue_valid = 1'b0; rs1_id = 5'd0; settle();
        chk("x0_busy", 32'(rs1_busy), 32'd0);
        chk("x0_val",  rs1_val, 32'd0);

        // rdy_in low freezes state and suppresses the RF write
        issue_valid = 1'b1; issue_rd = 5'd7; issue_tag = 3'd3; tick();
        rdy_in = 1'b0;
        issue_rd = 5'd8; issue_tag = 3'd1;
        commit_valid = 1'b1; commit_rd = 5'd7; commit_tag = 3'd3; commit_val = 32'h55;
        rs1_id = 5'd7; rs2_id = 5'd8; settle();
        chk("stall_rf_set_id", 32'(rf_set_id), 32'd0);
        chk("stall_no_bypass_busy", 32'(rs1_busy), 32'd1);
        chk("stall_rs1_val", rs1_val, 32'hA000_0007);
        tick();
        rdy_in = 1'b1; issue_valid = 1'b0; commit_valid = 1'b0; settle();
        chk("stall_x7_busy", 32'(rs1_busy), 32'd1);
        chk("stall_x7_tag",  32'(rs1_tag), 32'd3);
        chk("stall_x8_busy", 32'(rs2_busy), 32'd0);

        // Reset wins over rdy_in low
        rst_in = 1'b0; rdy_in = 1'b0; tick();
        rst_in = 1'b1; rdy_in = 1'b1; settle();
        chk("reset_x7_busy", 32'(rs1_busy), 32'd0);
        chk("reset_x7_tag",  32'(rs1_tag), 32'd0);

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule

`default_nettype wire
